// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared FSM state type, 4x4 key legend and helpers for the scanner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_NONE = 4'hF;

  // Row-major legend: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "D 0 E F".
  localparam logic [3:0] KEYMAP_4X4 [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hD, 4'h0, 4'hE, 4'hF
  };

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kp_sync.sv
// ============================================================================
// Module   : kp_sync
// Brief    : Parametrised-width two-flop synchroniser, async active-low reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module kp_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Brief    : Matrix keypad column scan, row debounce and key-code encode.
//            Optional auto-repeat enabled by `define KEYPAD_REPEAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS        = 4,
  parameter int N_COLS        = 4,
  parameter int SCAN_DIV      = 27,
  parameter int DB_CNT        = 270,
  parameter int REPEAT_DELAY  = 13_500_000,
  parameter int REPEAT_PERIOD = 2_700_000,
  localparam int CODE_W       = max2(4, $clog2(N_ROWS * N_COLS))
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [N_ROWS-1:0] rows_raw,
  output logic [N_COLS-1:0] columnas,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_key
);

  localparam int                c_CNT_W     = $clog2(max2(SCAN_DIV, DB_CNT) + 1);
  localparam logic [c_CNT_W-1:0] c_SCAN_LAST = c_CNT_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_DB_LAST   = c_CNT_W'(DB_CNT - 1);
  // All ones at any code width (KEY_NONE is the 4-bit all-ones code).
  localparam logic [CODE_W-1:0] c_CODE_RST  = ~CODE_W'(~KEY_NONE);
  localparam logic [N_COLS-1:0] c_COL_RST   = {1'b1, {(N_COLS-1){1'b0}}};

  if (N_ROWS < 2 || N_ROWS > 8 || N_COLS < 2 || N_COLS > 8 || SCAN_DIV < 1 ||
      DB_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  kp_state_t           r_state, w_state_nxt;
  logic [N_COLS-1:0]   r_col, w_col_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [N_ROWS-1:0]   r_pat, w_pat_nxt;
  logic [CODE_W-1:0]   r_code, w_code_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_held, w_held_nxt;
  logic                r_multi, w_multi_nxt;

  logic [N_ROWS-1:0]   w_rows_s;
  logic [N_COLS-1:0]   w_col_rot;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic                w_pat_single;
  logic                w_rows_multi;
  int                  w_row_idx;
  int                  w_col_idx;
  int                  w_lin;
  logic [CODE_W-1:0]   w_map_code;

  kp_sync #(
    .WIDTH (N_ROWS)
  ) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .i_d     (rows_raw),
    .o_q     (w_rows_s)
  );

  assign w_col_rot    = {r_col[0], r_col[N_COLS-1:1]};
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + c_CNT_W'(1);
  assign w_pat_single = ($countones(r_pat) == 1);
  assign w_rows_multi = ($countones(w_rows_s) > 1);

  // Bit N-1-k of a vector corresponds to row/column index k.
  always_comb begin
    w_row_idx = 0;
    w_col_idx = 0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (r_pat[i]) w_row_idx = N_ROWS - 1 - i;
    end
    for (int j = 0; j < N_COLS; j++) begin
      if (r_col[j]) w_col_idx = N_COLS - 1 - j;
    end
    w_lin = w_row_idx * N_COLS + w_col_idx;
    if (N_ROWS == 4 && N_COLS == 4) w_map_code = CODE_W'(KEYMAP_4X4[w_lin[3:0]]);
    else                            w_map_code = CODE_W'(w_lin);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int                c_REP_W       = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
  localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

  logic [c_REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic               r_rep_first, w_rep_first_nxt;
  logic [c_REP_W-1:0] w_rep_inc;

  assign w_rep_inc = (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + c_REP_W'(1);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_first <= w_rep_first_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= SCAN;
      r_col   <= c_COL_RST;
      r_cnt   <= '0;
      r_pat   <= '0;
      r_code  <= c_CODE_RST;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pat   <= w_pat_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_held  <= w_held_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_pat_nxt   = r_pat;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_held;
    w_multi_nxt = r_multi;
`ifdef KEYPAD_REPEAT_EN
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_first_nxt = r_rep_first;
`endif

    unique case (r_state)
      SCAN: begin
        // Rows are only trusted at the end of the dwell, after the column settles.
        if (r_cnt == c_SCAN_LAST) begin
          w_cnt_nxt = '0;
          if (w_rows_s == '0) begin
            w_col_nxt = w_col_rot;
          end else begin
            w_pat_nxt   = w_rows_s;
            w_state_nxt = DEBOUNCE;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      DEBOUNCE: begin
        if (w_rows_s != r_pat) begin
          w_state_nxt = SCAN;
          w_col_nxt   = w_col_rot;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          if (w_pat_single) begin
            w_code_nxt  = w_map_code;
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b1;
`endif
          end else begin
            w_multi_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      HELD: begin
        if (w_rows_s == '0) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          if (w_rows_s != r_pat) begin
            w_pat_nxt = w_rows_s;
            if (w_rows_multi) w_multi_nxt = 1'b1;
          end
`ifdef KEYPAD_REPEAT_EN
          if (r_held && !r_multi) begin
            if (r_rep_cnt == (r_rep_first ? c_DELAY_LAST : c_PERIOD_LAST)) begin
              w_valid_nxt     = 1'b1;
              w_rep_cnt_nxt   = '0;
              w_rep_first_nxt = 1'b0;
            end else begin
              w_rep_cnt_nxt = w_rep_inc;
            end
          end
`endif
        end
      end

      RELEASE: begin
        if (w_rows_s != '0) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = SCAN;
          w_held_nxt  = 1'b0;
          w_multi_nxt = 1'b0;
          w_col_nxt   = w_col_rot;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt = SCAN;
      end
    endcase
  end

  assign columnas  = r_col;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign multi_key = r_multi;

endmodule

`default_nettype wire
